// File: rtl/synth_pkg.sv
// synth_pkg: shared envelope state encoding and default envelope constants
package synth_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } env_state_t;
  localparam int          ENV_WIDTH        = 16;
  localparam logic [15:0] ENV_MAX          = 16'hFFFF;
  localparam logic [15:0] ATTACK_STEP_DEF  = 16'h0400;
  localparam logic [15:0] DECAY_STEP_DEF   = 16'h0100;
  localparam logic [15:0] RELEASE_STEP_DEF = 16'h0080;
endpackage

// File: rtl/sample_scaler.sv
// sample_scaler: two-stage signed sample x unsigned level multiply, floor-shifted by 8
module sample_scaler (
  input  logic       clk_in,
  input  logic       rst_in_n,
  input  logic       i_valid,
  input  logic [7:0] i_sample,
  input  logic [7:0] i_level,
  output logic [7:0] o_sample,
  output logic       o_valid
);
  logic [7:0]         r_sample;
  logic [7:0]         r_level;
  logic               r_valid1;
  logic signed [16:0] w_prod;
  assign w_prod = $signed(r_sample) * $signed({1'b0, r_level});
  // stage 1 captures the sample and the pre-update level; stage 2 registers the shaped result
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_sample <= '0;
      r_level  <= '0;
      r_valid1 <= 1'b0;
      o_sample <= '0;
      o_valid  <= 1'b0;
    end else begin
      r_valid1 <= i_valid;
      o_valid  <= r_valid1;
      if (i_valid) begin
        r_sample <= i_sample;
        r_level  <= i_level;
      end
      if (r_valid1) o_sample <= 8'(w_prod >>> 8);
    end
  end
endmodule

// File: rtl/adsr_envelope.sv
// adsr_envelope: per-sample ADSR state machine shaping signed tone samples by the envelope level
module adsr_envelope
  import synth_pkg::*;
#(
  parameter int               ENV_W        = ENV_WIDTH,
  parameter logic [ENV_W-1:0] ATTACK_STEP  = ATTACK_STEP_DEF,
  parameter logic [ENV_W-1:0] DECAY_STEP   = DECAY_STEP_DEF,
  parameter logic [ENV_W-1:0] RELEASE_STEP = RELEASE_STEP_DEF
) (
  input  logic       clk_in,
  input  logic       rst_in_n,
  input  logic       step_in,
  input  logic       gate_in,
  input  logic       trig_in,
  input  logic [7:0] sustain_in,
  input  logic [7:0] sample_in,
  output logic [7:0] sample_out,
  output logic       valid_out,
  output logic [7:0] env_out,
  output logic [2:0] state_out
);
  localparam logic [ENV_W-1:0] L_MAX = {ENV_W{1'b1}};
  env_state_t       r_state, w_state_nxt;
  logic [ENV_W-1:0] r_env, w_env_nxt, w_floor;
  logic [ENV_W:0]   w_sum, w_diff;
  logic             r_trig;
  assign w_floor   = {sustain_in, {(ENV_W-8){1'b0}}};
  assign w_sum     = {1'b0, r_env} + {1'b0, ATTACK_STEP};
  assign w_diff    = {1'b0, r_env} - {1'b0, DECAY_STEP};
  assign env_out   = r_env[ENV_W-1:ENV_W-8];
  assign state_out = r_state;
  // gate/retrigger transitions take priority and hold env; otherwise advance the current phase
  always_comb begin
    w_state_nxt = r_state;
    w_env_nxt   = r_env;
    if (!gate_in && (r_state == ATTACK || r_state == DECAY || r_state == SUSTAIN)) begin
      w_state_nxt = RELEASE;
    end else if (gate_in && (r_state == IDLE || r_state == RELEASE || r_trig)) begin
      w_state_nxt = ATTACK;
    end else begin
      case (r_state)
        IDLE: w_env_nxt = '0;
        ATTACK: begin
          w_env_nxt   = (w_sum > {1'b0, L_MAX}) ? L_MAX : w_sum[ENV_W-1:0];
          w_state_nxt = (w_env_nxt == L_MAX) ? DECAY : ATTACK;
        end
        DECAY: begin
          w_env_nxt   = ($signed(w_diff) <= $signed({1'b0, w_floor})) ? w_floor : w_diff[ENV_W-1:0];
          w_state_nxt = ($signed(w_diff) <= $signed({1'b0, w_floor})) ? SUSTAIN : DECAY;
        end
        SUSTAIN: w_env_nxt = w_floor;
        RELEASE: begin
          w_env_nxt   = (r_env <= RELEASE_STEP) ? '0 : r_env - RELEASE_STEP;
          w_state_nxt = (r_env <= RELEASE_STEP) ? IDLE : RELEASE;
        end
        default: begin
          w_env_nxt   = '0;
          w_state_nxt = IDLE;
        end
      endcase
    end
  end
  // state and env advance on sample strobes; a retrigger pulse is remembered until the next strobe
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_state <= IDLE;
      r_env   <= '0;
      r_trig  <= 1'b0;
    end else begin
      if (step_in) begin
        r_state <= w_state_nxt;
        r_env   <= w_env_nxt;
      end
      r_trig <= trig_in | (r_trig & ~step_in);
    end
  end
  sample_scaler u_scaler (
    .clk_in  (clk_in),
    .rst_in_n(rst_in_n),
    .i_valid (step_in),
    .i_sample(sample_in),
    .i_level (r_env[ENV_W-1:ENV_W-8]),
    .o_sample(sample_out),
    .o_valid (valid_out)
  );
endmodule

// File: tb/tb_adsr_envelope.sv
// tb_adsr_envelope: random and directed checks of adsr_envelope against a behavioural envelope model
module tb_adsr_envelope;
  import synth_pkg::*;
  logic       clk_in = 1'b0;
  logic       rst_in_n = 1'b0;
  logic       step_in = 1'b0;
  logic       gate_in = 1'b0;
  logic       trig_in = 1'b0;
  logic [7:0] sustain_in = 8'h00;
  logic [7:0] sample_in = 8'h00;
  logic [7:0] sample_out;
  logic       valid_out;
  logic [7:0] env_out;
  logic [2:0] state_out;
  int checks = 0;
  int failures = 0;
  int m_env, m_st, m_trig, m_p1v, m_p1s, m_vout, m_sout;
  bit chk_en = 1'b0;
  adsr_envelope dut (
    .clk_in    (clk_in),
    .rst_in_n  (rst_in_n),
    .step_in   (step_in),
    .gate_in   (gate_in),
    .trig_in   (trig_in),
    .sustain_in(sustain_in),
    .sample_in (sample_in),
    .sample_out(sample_out),
    .valid_out (valid_out),
    .env_out   (env_out),
    .state_out (state_out)
  );
  always #5 clk_in = ~clk_in;
  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask
  function automatic int scale(int s, int e);
    int p;
    p = s * e;
    return (p >= 0) ? p / 256 : -((-p + 255) / 256);
  endfunction
  task automatic model_reset();
    m_env = 0; m_st = 0; m_trig = 0; m_p1v = 0; m_p1s = 0; m_vout = 0; m_sout = 0;
  endtask
  task automatic model_step();
    int fl, s;
    fl = sustain_in * 256;
    s = $signed(sample_in);
    m_vout = m_p1v;
    if (m_p1v != 0) m_sout = m_p1s;
    m_p1v = step_in;
    if (step_in) begin
      m_p1s = scale(s, m_env / 256);
      if (!gate_in && m_st >= 1 && m_st <= 3) m_st = 4;
      else if (gate_in && (m_st == 0 || m_st == 4 || m_trig != 0)) m_st = 1;
      else if (m_st == 0) m_env = 0;
      else if (m_st == 1) begin
        m_env = (m_env + 'h400 > 65535) ? 65535 : m_env + 'h400;
        if (m_env == 65535) m_st = 2;
      end else if (m_st == 2) begin
        if (m_env - 'h100 <= fl) begin m_env = fl; m_st = 3; end
        else m_env = m_env - 'h100;
      end else if (m_st == 3) m_env = fl;
      else begin
        if (m_env <= 'h80) begin m_env = 0; m_st = 0; end
        else m_env = m_env - 'h80;
      end
      m_trig = trig_in;
    end else if (trig_in) m_trig = 1;
  endtask
  always @(negedge clk_in) begin
    if (rst_in_n && chk_en) begin
      check("env_out", env_out, m_env / 256);
      check("state_out", state_out, m_st);
      check("valid_out", valid_out, m_vout);
      if (m_vout != 0) check("sample_out", $signed(sample_out), m_sout);
    end
  end
  task automatic tick(bit st, bit g, bit tr, int smp);
    step_in = st; gate_in = g; trig_in = tr; sample_in = 8'(smp);
    @(posedge clk_in);
    model_step();
    @(negedge clk_in);
    step_in = 1'b0; trig_in = 1'b0;
  endtask
  task automatic stepg(bit g, int smp);
    tick(1'b1, g, 1'b0, smp);
    tick(1'b0, g, 1'b0, 0);
  endtask
  task automatic run_until(int st, int budget);
    int n;
    n = 0;
    while (m_st != st && n < budget) begin
      stepg(1'b1, int'($urandom_range(0, 255)));
      n++;
    end
    check("reach_state", state_out, st);
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end
  initial begin
    bit vp[5];
    model_reset();
    repeat (3) @(negedge clk_in);
    check("rst_sample_out", sample_out, 0);
    check("rst_valid_out", valid_out, 0);
    check("rst_env_out", env_out, 0);
    check("rst_state_out", state_out, 0);
    rst_in_n = 1'b1;
    chk_en = 1'b1;
    sustain_in = 8'h80;
    stepg(1'b1, 0);
    check("atk_first_state", state_out, 1);
    check("atk_first_env", env_out, 8'h00);
    repeat (63) stepg(1'b1, 0);
    check("atk_63_env", env_out, 8'hFC);
    stepg(1'b1, 0);
    check("atk_peak_state", state_out, 2);
    check("atk_peak_env", env_out, 8'hFF);
    check("atk_peak_model", m_env, int'(ENV_MAX));
    stepg(1'b1, -128);
    check("scale_m128_ff", $signed(sample_out), -128);
    repeat (126) stepg(1'b1, 0);
    check("decay_127_state", state_out, 2);
    stepg(1'b1, 0);
    check("sustain_state", state_out, 3);
    check("sustain_env", env_out, 8'h80);
    check("sustain_model", m_env, 'h8000);
    stepg(1'b1, 100);
    check("scale_100_80", $signed(sample_out), 50);
    check("scale_valid", valid_out, 1);
    sustain_in = 8'hFF;
    stepg(1'b1, 0);
    check("sustain_track", env_out, 8'hFF);
    stepg(1'b1, 127);
    check("scale_127_ff", $signed(sample_out), 126);
    stepg(1'b1, -128);
    check("scale_m128_ff2", $signed(sample_out), -128);
    sustain_in = 8'h80;
    stepg(1'b1, 0);
    tick(1'b0, 1'b1, 1'b1, 0);
    stepg(1'b1, 0);
    check("retrig_state", state_out, 1);
    check("retrig_env", env_out, 8'h80);
    stepg(1'b1, 0);
    check("retrig_env_next", env_out, 8'h84);
    run_until(3, 400);
    stepg(1'b0, 0);
    check("rel_state", state_out, 4);
    check("rel_env", env_out, 8'h80);
    repeat (255) stepg(1'b0, 0);
    check("rel_255_state", state_out, 4);
    stepg(1'b0, 0);
    check("rel_idle_state", state_out, 0);
    check("rel_idle_model", m_env, 0);
    run_until(3, 400);
    stepg(1'b0, 0);
    repeat (128) stepg(1'b0, 0);
    check("rel_half_env", env_out, 8'h40);
    stepg(1'b1, 0);
    check("repress_state", state_out, 1);
    check("repress_env", env_out, 8'h40);
    stepg(1'b1, 0);
    check("repress_env_next", env_out, 8'h44);
    run_until(3, 400);
    tick(1'b0, 1'b1, 1'b1, 0);
    stepg(1'b0, 0);
    check("discard_state", state_out, 4);
    stepg(1'b1, 0);
    check("discard_attack", state_out, 1);
    stepg(1'b1, 0);
    check("discard_env_next", env_out, 8'h84);
    stepg(1'b1, 100);
    #2 rst_in_n = 1'b0;
    #1;
    check("arst_sample_out", sample_out, 0);
    check("arst_valid_out", valid_out, 0);
    check("arst_env_out", env_out, 0);
    check("arst_state_out", state_out, 0);
    model_reset();
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in_n = 1'b1;
    tick(1'b1, 1'b1, 1'b0, 10);
    vp[0] = valid_out;
    tick(1'b1, 1'b1, 1'b0, 20);
    vp[1] = valid_out;
    tick(1'b1, 1'b1, 1'b0, 30);
    vp[2] = valid_out;
    tick(1'b0, 1'b1, 1'b0, 0);
    vp[3] = valid_out;
    tick(1'b0, 1'b1, 1'b0, 0);
    vp[4] = valid_out;
    check("b2b_v0", int'(vp[0]), 0);
    check("b2b_v1", int'(vp[1]), 1);
    check("b2b_v2", int'(vp[2]), 1);
    check("b2b_v3", int'(vp[3]), 1);
    check("b2b_v4", int'(vp[4]), 0);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 59) == 0) gate_in = ~gate_in;
      if ($urandom_range(0, 149) == 0) sustain_in = 8'($urandom_range(0, 255));
      tick(1'($urandom_range(0, 1)), gate_in, $urandom_range(0, 15) == 0, int'($urandom_range(0, 255)));
    end
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
